// File: rtl/ex_stage_pkg.sv
// Shared widths, stall encodings, divider states and the ID->EX bundle.
// Imported by ex_stage and div_iter.
package ex_stage_pkg;

    localparam int EX_TO_MEM_WD = 76;
    localparam int EX_TO_RF_WD  = 38;
    localparam int ID_TO_EX_WD  = 159;
    localparam int StallBus     = 6;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_BUSY = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    localparam logic [5:0] FN_DIV  = 6'b011010;
    localparam logic [5:0] FN_DIVU = 6'b011011;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MFLO = 6'b010010;
    localparam logic [5:0] FN_MTHI = 6'b010001;
    localparam logic [5:0] FN_MTLO = 6'b010011;

    // alu_op bit positions, add is the MSB
    localparam int ALU_ADD  = 11;
    localparam int ALU_SUB  = 10;
    localparam int ALU_SLT  = 9;
    localparam int ALU_SLTU = 8;
    localparam int ALU_AND  = 7;
    localparam int ALU_NOR  = 6;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 3;
    localparam int ALU_SRL  = 2;
    localparam int ALU_SRA  = 1;
    localparam int ALU_LUI  = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  src1;
        logic [3:0]  src2;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
    } id_ex_t;

endpackage

// File: rtl/ex_stage_div_iter.sv
// 32-step restoring divider for div/divu with sign fixup in DONE.
// Ports: clk, rst, start, signed_op, a, b -> busy, done, quotient, remainder.
module div_iter
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [1:0]  r_state;
    logic [4:0]  r_count;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_dvsr;
    logic        r_neg_q;
    logic        r_neg_r;

    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_diff;

    assign w_abs_a = (signed_op & a[31]) ? -a : a;
    assign w_abs_b = (signed_op & b[31]) ? -b : b;

    // r_quo starts as the dividend and shifts its MSB into the remainder
    assign w_shift = {r_rem, r_quo[31]};
    assign w_ge    = w_shift >= {1'b0, r_dvsr};
    // true difference is below 2^32 whenever it is used
    assign w_diff  = w_shift[31:0] - r_dvsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DIV_IDLE;
            r_count <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dvsr  <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (start) begin
                        r_quo   <= w_abs_a;
                        r_dvsr  <= w_abs_b;
                        r_rem   <= '0;
                        r_neg_q <= signed_op & (a[31] ^ b[31]);
                        r_neg_r <= signed_op & a[31];
                        r_count <= '0;
                        r_state <= DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    r_rem   <= w_ge ? w_diff : w_shift[31:0];
                    r_quo   <= {r_quo[30:0], w_ge};
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'd31) begin
                        r_state <= DIV_DONE;
                    end
                end
                DIV_DONE: r_state <= DIV_IDLE;
                default:  r_state <= DIV_IDLE;
            endcase
        end
    end

    assign busy      = (r_state == DIV_BUSY);
    assign done      = (r_state == DIV_DONE);
    assign quotient  = r_neg_q ? -r_quo : r_quo;
    assign remainder = r_neg_r ? -r_rem : r_rem;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: input register, ALU, SRAM request, forwarding, HI/LO.
// Ports: clk, rst, stall, id_to_ex_bus -> ex_to_mem_bus, ex_to_rf_bus,
// ex_is_load, data_sram_{en,wen,addr,wdata}, stallreq_for_ex.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [StallBus-1:0]     stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
    output logic                    ex_is_load,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata,
    output logic                    stallreq_for_ex
);

    id_ex_t      r_ex;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex <= '0;
        end else if (stall[2] == Stop && stall[3] == NoStop) begin
            r_ex <= '0;
        end else if (stall[2] == NoStop) begin
            r_ex <= id_to_ex_bus;
        end
    end

    logic [15:0] w_imm;
    logic [31:0] w_sext;
    logic [31:0] w_zext;
    logic [31:0] w_sa;
    logic [31:0] w_src1;
    logic [31:0] w_src2;

    assign w_imm  = r_ex.inst[15:0];
    assign w_sext = {{16{w_imm[15]}}, w_imm};
    assign w_zext = {16'b0, w_imm};
    assign w_sa   = {27'b0, r_ex.inst[10:6]};

    assign w_src1 = ({32{r_ex.src1[0]}} & r_ex.rs_val)
                  | ({32{r_ex.src1[1]}} & r_ex.pc)
                  | ({32{r_ex.src1[2]}} & w_sa);

    assign w_src2 = ({32{r_ex.src2[0]}} & r_ex.rt_val)
                  | ({32{r_ex.src2[1]}} & w_sext)
                  | ({32{r_ex.src2[2]}} & 32'd8)
                  | ({32{r_ex.src2[3]}} & w_zext);

    logic [11:0] w_op;
    logic [4:0]  w_sh;
    logic [31:0] w_sra;
    logic [31:0] w_alu;

    assign w_op  = r_ex.alu_op;
    assign w_sh  = w_src1[4:0];
    assign w_sra = $signed(w_src2) >>> w_sh;

    assign w_alu =
          ({32{w_op[ALU_ADD]}}  & (w_src1 + w_src2))
        | ({32{w_op[ALU_SUB]}}  & (w_src1 - w_src2))
        | ({32{w_op[ALU_SLT]}}
           & {31'b0, $signed(w_src1) < $signed(w_src2)})
        | ({32{w_op[ALU_SLTU]}} & {31'b0, w_src1 < w_src2})
        | ({32{w_op[ALU_AND]}}  & (w_src1 & w_src2))
        | ({32{w_op[ALU_NOR]}}  & ~(w_src1 | w_src2))
        | ({32{w_op[ALU_OR]}}   & (w_src1 | w_src2))
        | ({32{w_op[ALU_XOR]}}  & (w_src1 ^ w_src2))
        | ({32{w_op[ALU_SLL]}}  & (w_src2 << w_sh))
        | ({32{w_op[ALU_SRL]}}  & (w_src2 >> w_sh))
        | ({32{w_op[ALU_SRA]}}  & w_sra)
        | ({32{w_op[ALU_LUI]}}  & {w_imm, 16'b0});

    logic       w_op0;
    logic [5:0] w_fn;
    logic       w_is_div;
    logic       w_is_divu;
    logic       w_div_any;
    logic       w_is_mfhi;
    logic       w_is_mflo;
    logic       w_is_mthi;
    logic       w_is_mtlo;

    assign w_op0     = (r_ex.inst[31:26] == 6'd0);
    assign w_fn      = r_ex.inst[5:0];
    assign w_is_div  = w_op0 & (w_fn == FN_DIV);
    assign w_is_divu = w_op0 & (w_fn == FN_DIVU);
    assign w_div_any = w_is_div | w_is_divu;
    assign w_is_mfhi = w_op0 & (w_fn == FN_MFHI);
    assign w_is_mflo = w_op0 & (w_fn == FN_MFLO);
    assign w_is_mthi = w_op0 & (w_fn == FN_MTHI);
    assign w_is_mtlo = w_op0 & (w_fn == FN_MTLO);

    logic        w_busy;
    logic        w_done;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    // start is ignored outside IDLE, so a div still in EX during DONE
    // does not launch a second run
    div_iter u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (w_div_any),
        .signed_op (w_is_div),
        .a         (r_ex.rs_val),
        .b         (r_ex.rt_val),
        .busy      (w_busy),
        .done      (w_done),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    assign stallreq_for_ex = (w_div_any & ~w_busy & ~w_done) | w_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_done) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
        end else if (stall[3] == NoStop) begin
            if (w_is_mthi) r_hi <= r_ex.rs_val;
            if (w_is_mtlo) r_lo <= r_ex.rs_val;
        end
    end

    logic [31:0] w_result;

    always_comb begin
        w_result = w_alu;
        unique case (1'b1)
            w_is_mfhi: w_result = r_hi;
            w_is_mflo: w_result = r_lo;
            default:   w_result = w_alu;
        endcase
    end

    logic w_any_wen;

    assign w_any_wen       = |r_ex.ram_wen;
    assign data_sram_en    = r_ex.ram_en | w_any_wen;
    assign data_sram_wen   = {4{w_any_wen}};
    assign data_sram_addr  = w_alu;
    assign data_sram_wdata = r_ex.rt_val;
    assign ex_is_load      = r_ex.ram_en & ~w_any_wen;

    assign ex_to_mem_bus = {r_ex.pc, r_ex.ram_en, r_ex.ram_wen,
                            r_ex.sel_rf_res, r_ex.rf_we,
                            r_ex.rf_waddr, w_result};
    assign ex_to_rf_bus  = {r_ex.rf_we, r_ex.rf_waddr, w_result};

    logic w_unused;
    assign w_unused = ^{stall[5:4], stall[1:0], r_ex.inst[25:16]};

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: reference model plus directed literals.
// Drives random instruction streams and emulates the stall controller.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic [158:0] bus_in;
    logic [75:0]  ex_to_mem_bus;
    logic [37:0]  ex_to_rf_bus;
    logic         ex_is_load;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         stallreq_for_ex;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .id_to_ex_bus    (bus_in),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .ex_to_rf_bus    (ex_to_rf_bus),
        .ex_is_load      (ex_is_load),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .stallreq_for_ex (stallreq_for_ex)
    );

    int vecs = 0;
    int errs = 0;

    logic [158:0] m_reg;
    logic [31:0]  m_hi;
    logic [31:0]  m_lo;
    int           m_age;

    task automatic check(input string nm, input logic [79:0] got,
                         input logic [79:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [158:0] mk(
        input logic [31:0] pc, input logic [31:0] inst,
        input logic [11:0] op, input logic [2:0] s1, input logic [3:0] s2,
        input logic re, input logic [3:0] we, input logic rfwe,
        input logic [4:0] wa, input logic sel,
        input logic [31:0] rs, input logic [31:0] rt);
        return {pc, inst, op, s1, s2, re, we, rfwe, wa, sel, rs, rt};
    endfunction

    function automatic logic [5:0] fn_of(input logic [158:0] b);
        logic [31:0] inst;
        inst = b[126:95];
        if (inst[31:26] != 6'd0) return 6'h3f;
        return inst[5:0];
    endfunction

    function automatic bit is_div(input logic [158:0] b);
        return fn_of(b) == 6'h1a || fn_of(b) == 6'h1b;
    endfunction

    function automatic logic [31:0] m_alu(input logic [158:0] b);
        logic [31:0] pc, inst, rs, rt, s1, s2, r, imm;
        logic [11:0] op;
        int sh;
        pc = b[158:127]; inst = b[126:95];
        rs = b[63:32];   rt = b[31:0];
        op = b[94:83];
        imm = {16'b0, inst[15:0]};
        if (b[80])      s1 = rs;
        else if (b[81]) s1 = pc;
        else if (b[82]) s1 = imm[10:6] & 32'h1f;
        else            s1 = 0;
        if (b[76])      s2 = rt;
        else if (b[77]) s2 = imm[15] ? imm | 32'hffff0000 : imm;
        else if (b[78]) s2 = 8;
        else if (b[79]) s2 = imm;
        else            s2 = 0;
        sh = int'(s1 % 32);
        r = 0;
        if (op[11]) r |= s1 + s2;
        if (op[10]) r |= s1 - s2;
        if (op[9])  r |= ($signed(s1) < $signed(s2)) ? 1 : 0;
        if (op[8])  r |= (s1 < s2) ? 1 : 0;
        if (op[7])  r |= s1 & s2;
        if (op[6])  r |= ~(s1 | s2);
        if (op[5])  r |= s1 | s2;
        if (op[4])  r |= s1 ^ s2;
        if (op[3])  r |= s2 << sh;
        if (op[2])  r |= s2 >> sh;
        if (op[1])  r |= 32'($signed(s2) >>> sh);
        if (op[0])  r |= imm << 16;
        return r;
    endfunction

    task automatic m_divide(input logic [158:0] b,
                            output logic [31:0] q, output logic [31:0] rm);
        logic [31:0] a, d, ma, md;
        bit sg;
        a = b[63:32]; d = b[31:0];
        sg = (fn_of(b) == 6'h1a);
        ma = (sg && a[31]) ? 0 - a : a;
        md = (sg && d[31]) ? 0 - d : d;
        if (md == 0) begin
            q = 32'hffffffff; rm = ma;
        end else begin
            q = ma / md; rm = ma % md;
        end
        if (sg && (a[31] != d[31])) q = 0 - q;
        if (sg && a[31]) rm = 0 - rm;
    endtask

    function automatic bit m_stallreq();
        return is_div(m_reg) && m_age < 33;
    endfunction

    task automatic model_step(input logic [158:0] b, input logic [5:0] st,
                              input logic r);
        logic [31:0] q, rm;
        if (r) begin
            m_reg = 0; m_hi = 0; m_lo = 0; m_age = 0;
            return;
        end
        if (is_div(m_reg) && m_age == 33) begin
            m_divide(m_reg, q, rm);
            m_lo = q; m_hi = rm;
        end else if (!st[3]) begin
            if (fn_of(m_reg) == 6'h11) m_hi = m_reg[63:32];
            if (fn_of(m_reg) == 6'h13) m_lo = m_reg[63:32];
        end
        if (st[2] && !st[3]) begin
            m_reg = 0; m_age = 0;
        end else if (!st[2]) begin
            m_reg = b; m_age = 0;
        end else begin
            m_age++;
        end
    endtask

    task automatic compare_all();
        logic [31:0] res;
        logic [3:0] we;
        logic re;
        res = m_alu(m_reg);
        if (fn_of(m_reg) == 6'h10) res = m_hi;
        if (fn_of(m_reg) == 6'h12) res = m_lo;
        we = m_reg[74:71];
        re = m_reg[75];
        check("mem_bus", 80'(ex_to_mem_bus),
              80'({m_reg[158:127], re, we, m_reg[64], m_reg[70],
                   m_reg[69:65], res}));
        check("rf_bus", 80'(ex_to_rf_bus),
              80'({m_reg[70], m_reg[69:65], res}));
        check("is_load", 80'(ex_is_load), 80'(re && we == 0));
        check("sram_en", 80'(data_sram_en), 80'(re || we != 0));
        check("sram_wen", 80'(data_sram_wen), 80'(we != 0 ? 4'hf : 4'h0));
        check("sram_addr", 80'(data_sram_addr), 80'(m_alu(m_reg)));
        check("sram_wdata", 80'(data_sram_wdata), 80'(m_reg[31:0]));
        check("stallreq", 80'(stallreq_for_ex), 80'(m_stallreq()));
    endtask

    // one clock: the stall controller ORs in the EX stall request
    task automatic cyc(input logic [158:0] b, input logic [5:0] st,
                       input logic r);
        logic [5:0] eff;
        eff = m_stallreq() ? (st | 6'b001111) : st;
        bus_in = b; stall = eff; rst = r;
        @(posedge clk);
        model_step(b, eff, r);
        #1;
        compare_all();
    endtask

    function automatic logic [158:0] r_type(input logic [5:0] fn,
        input logic rfwe, input logic [31:0] rs, input logic [31:0] rt);
        logic [31:0] inst;
        inst = {6'd0, 5'd1, 5'd2, 5'd8, 5'd0, fn};
        return mk(32'h400, inst, 12'h0, 3'b001, 4'b0001, 1'b0, 4'h0,
                  rfwe, 5'd8, 1'b0, rs, rt);
    endfunction

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return 0;
            1: return 32'h80000000;
            2: return $urandom_range(0, 20);
            3: return 0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [158:0] rand_bus();
        logic [31:0] inst;
        logic [11:0] op;
        logic [2:0] s1;
        logic [3:0] s2;
        int k;
        k = $urandom_range(0, 11);
        inst = $urandom;
        inst[31:26] = 6'($urandom_range(1, 63));
        op = ($urandom_range(0, 12) == 0) ? 12'h0
             : 12'h1 << $urandom_range(0, 11);
        s1 = 3'b1 << $urandom_range(0, 2);
        s2 = 4'b1 << $urandom_range(0, 3);
        case (k)
            7: return mk($urandom, inst, 12'h800, 3'b001, 4'b0010, 1'b1,
                         ($urandom_range(0, 1) != 0) ? 4'hf : 4'h0,
                         1'($urandom), 5'($urandom), 1'($urandom),
                         $urandom, $urandom);
            8: return r_type(($urandom_range(0, 1) != 0) ? 6'h11 : 6'h13,
                             1'b0, $urandom, $urandom);
            9: return r_type(($urandom_range(0, 1) != 0) ? 6'h10 : 6'h12,
                             1'b1, $urandom, $urandom);
            10: if ($urandom_range(0, 2) == 0)
                    return r_type(($urandom_range(0, 1) != 0) ? 6'h1a : 6'h1b,
                                  1'b0, rnd_opnd(), rnd_opnd());
            default: ;
        endcase
        return mk($urandom, inst, op, s1, s2, 1'b0, 4'h0, 1'($urandom),
                  5'($urandom), 1'($urandom), rnd_opnd(), rnd_opnd());
    endfunction

    logic [158:0] b_addu, b_lui, b_jal, b_sw;
    logic [5:0]   st;
    int           n;

    initial begin
        m_reg = 0; m_hi = 0; m_lo = 0; m_age = 0;
        bus_in = 0; stall = 0; rst = 1;

        cyc(159'(0), 6'h0, 1'b1);
        check("rst_rf", 80'(ex_to_rf_bus), 80'(0));
        check("rst_mem", 80'(ex_to_mem_bus), 80'(0));
        check("rst_stq", 80'(stallreq_for_ex), 80'(0));

        b_addu = mk(32'h100, {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 12'h800,
                    3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0,
                    32'd5, 32'd7);
        cyc(b_addu, 6'h0, 1'b0);
        check("addu_lit", 80'(ex_to_rf_bus), 80'({1'b1, 5'd3, 32'd12}));

        b_lui = mk(32'h104, {6'h0f, 5'd0, 5'd4, 16'h1234}, 12'h001, 3'b001,
                   4'b1000, 1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'd0, 32'd0);
        cyc(b_lui, 6'h0, 1'b0);
        check("lui_lit", 80'(ex_to_rf_bus[31:0]), 80'(32'h12340000));

        b_jal = mk(32'hBFC00010, {6'h03, 26'h0}, 12'h800, 3'b010, 4'b0100,
                   1'b0, 4'h0, 1'b1, 5'd31, 1'b0, 32'd0, 32'd0);
        cyc(b_jal, 6'h0, 1'b0);
        check("jal_lit", 80'(ex_to_rf_bus),
              80'({1'b1, 5'd31, 32'hBFC00018}));

        b_sw = mk(32'h108, {6'h2b, 5'd5, 5'd6, 16'hFFFC}, 12'h800, 3'b001,
                  4'b0010, 1'b1, 4'hf, 1'b0, 5'd0, 1'b0,
                  32'h1000, 32'hDEADBEEF);
        cyc(b_sw, 6'h0, 1'b0);
        check("sw_en", 80'(data_sram_en), 80'(1));
        check("sw_wen", 80'(data_sram_wen), 80'(4'hf));
        check("sw_addr", 80'(data_sram_addr), 80'(32'h0FFC));
        check("sw_wdata", 80'(data_sram_wdata), 80'(32'hDEADBEEF));

        cyc(r_type(6'h1b, 1'b0, 32'd100, 32'd7), 6'h0, 1'b0);
        n = stallreq_for_ex ? 1 : 0;
        repeat (40) begin
            cyc(159'(0), 6'h0, 1'b0);
            if (stallreq_for_ex) n++;
        end
        check("divu_stall_len", 80'(n), 80'(33));
        cyc(r_type(6'h12, 1'b1, 32'd0, 32'd0), 6'h0, 1'b0);
        check("divu_lo", 80'(ex_to_rf_bus[31:0]), 80'(14));
        cyc(r_type(6'h10, 1'b1, 32'd0, 32'd0), 6'h0, 1'b0);
        check("divu_hi", 80'(ex_to_rf_bus[31:0]), 80'(2));

        cyc(r_type(6'h1a, 1'b0, 32'hFFFFFFF9, 32'd2), 6'h0, 1'b0);
        repeat (34) cyc(159'(0), 6'h0, 1'b0);
        cyc(r_type(6'h12, 1'b1, 32'd0, 32'd0), 6'h0, 1'b0);
        check("div_neg_lo", 80'(ex_to_rf_bus[31:0]), 80'(32'hFFFFFFFD));
        cyc(r_type(6'h10, 1'b1, 32'd0, 32'd0), 6'h0, 1'b0);
        check("div_neg_hi", 80'(ex_to_rf_bus[31:0]), 80'(32'hFFFFFFFF));

        cyc(r_type(6'h1a, 1'b0, 32'd5, 32'd0), 6'h0, 1'b0);
        repeat (34) cyc(159'(0), 6'h0, 1'b0);
        cyc(r_type(6'h12, 1'b1, 32'd0, 32'd0), 6'h0, 1'b0);
        check("div0_lo", 80'(ex_to_rf_bus[31:0]), 80'(32'hFFFFFFFF));
        cyc(r_type(6'h10, 1'b1, 32'd0, 32'd0), 6'h0, 1'b0);
        check("div0_hi", 80'(ex_to_rf_bus[31:0]), 80'(5));

        cyc(r_type(6'h1b, 1'b0, 32'd100, 32'd7), 6'h0, 1'b0);
        repeat (11) cyc(159'(0), 6'h0, 1'b0);
        check("busy_before_rst", 80'(stallreq_for_ex), 80'(1));
        cyc(159'(0), 6'h0, 1'b1);
        check("rst_drops_stq", 80'(stallreq_for_ex), 80'(0));
        cyc(r_type(6'h10, 1'b1, 32'd0, 32'd0), 6'h0, 1'b0);
        check("rst_hi", 80'(ex_to_rf_bus[31:0]), 80'(0));
        cyc(r_type(6'h12, 1'b1, 32'd0, 32'd0), 6'h0, 1'b0);
        check("rst_lo", 80'(ex_to_rf_bus[31:0]), 80'(0));

        cyc(b_addu, 6'h0, 1'b0);
        cyc(b_sw, 6'b000111, 1'b0);
        check("bubble_rfwe", 80'(ex_to_rf_bus[37]), 80'(0));
        check("bubble_sram", 80'(data_sram_en), 80'(0));

        for (int i = 0; i < 1500; i++) begin
            st = 6'h0;
            if (!is_div(m_reg)) begin
                case ($urandom_range(0, 9))
                    0: st = 6'b001111;
                    1: st = 6'b000111;
                    default: st = 6'h0;
                endcase
            end
            cyc(rand_bus(), st, ($urandom_range(0, 199) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage MIPS pipeline, sitting between the ID and MEM stages. It registers the ID→EX bus under stall control and evaluates the one-hot ALU operation. It issues the data-SRAM request for lw/sw and drives the EX forwarding bus back to ID. It also owns the HI/LO registers and a 32-cycle iterative divider for div/divu, stalling the pipeline through `stallreq_for_ex` while the divider is busy.

## Interface
Parameters:
- none. Bus widths come from the shared `defines.vh`.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `stall`  in  `StallBus`(6)  pipeline stall vector
  - `stall[2]` gates the EX input register.
  - `stall[3]` gates the EX output.
- `id_to_ex_bus`  in  159  bit fields:
  - `pc[158:127]`, `inst[126:95]`
  - `alu_op[94:83]`, `src1[82:80]`, `src2[79:76]`
  - `ram_en[75]`, `ram_wen[74:71]`
  - `rf_we[70]`, `rf_waddr[69:65]`, `sel_rf_res[64]`
  - `rs_val[63:32]`, `rt_val[31:0]`
- `ex_to_mem_bus`  out  76  `{pc, ram_en, ram_wen[3:0], sel_rf_res, rf_we, rf_waddr, ex_result}`
- `ex_to_rf_bus`  out  38  `{rf_we, rf_waddr, ex_result}`, the forwarding path to ID
- `ex_is_load`  out  1  the instruction in EX is lw; ID uses it for load-use stalling
- `data_sram_en`  out  1  data SRAM request
- `data_sram_wen`  out  4  data SRAM byte write enables
- `data_sram_addr`  out  32  data SRAM address
- `data_sram_wdata`  out  32  data SRAM write data
- `stallreq_for_ex`  out  1  divider-busy stall request

## Operation
Input register:
- On reset, load zero.
- Else if `stall[2]`=Stop and `stall[3]`=NoStop, load zero (bubble).
- Else if `stall[2]`=NoStop, load `id_to_ex_bus`.
- Otherwise hold.

ALU operand selects:
- src1 (one-hot): rs_val, pc, or `{27'b0, inst[10:6]}`.
- src2 (one-hot): rt_val, sign-extended imm, 32'd8, or zero-extended imm.

ALU operations:
- Order, MSB first: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
- add/sub wrap modulo 2^32 with no overflow trap.
- slt compares signed; sltu compares unsigned.
- Shifts shift src2 by `src1[4:0]`.
- lui gives `{imm, 16'b0}`.
- `alu_op` = 0 gives result 0.

Local decode (opcode 0, func):
- div = 011010, divu = 011011
- mfhi = 010000, mflo = 010010
- mthi = 010001, mtlo = 010011

`ex_result` selection:
- mfhi → HI
- mflo → LO
- otherwise → ALU result

HI/LO writes:
- mthi/mtlo write rs_val when the instruction advances (`stall[3]`=NoStop).
- Divider results are written in the DONE state.

Memory request:
- `data_sram_en` = ram_en | (|ram_wen)
- `data_sram_wen` = {4{|ram_wen}}
- `data_sram_addr` = ALU result
- `data_sram_wdata` = rt_val
- `ex_is_load` = ram_en & ~(|ram_wen)

Divider FSM (IDLE, BUSY, DONE):
- IDLE: when div/divu is in EX, latch operand magnitudes and signs. For divu the magnitudes are taken as-is. Set count = 0 and go to BUSY.
- BUSY: one restoring-division step per cycle. Leave for DONE after count reaches 31, i.e. 32 steps.
- DONE: sign-fix the results. Quotient is negated if the operand signs differ; remainder takes the dividend's sign. Write LO = quotient and HI = remainder, then return to IDLE.
- Divide by zero raises no trap. LO = 32'hFFFFFFFF and HI = dividend magnitude, then the sign fixup is applied.

Bubbles: an all-zero input register produces all-zero buses with rf_we = 0.

## Timing
- Everything outside the registers (ALU, memory request, forwarding) is combinational from the input register, so results are available the same cycle.
- `stallreq_for_ex` = ((IDLE & div) | BUSY), i.e. high in the detect cycle and all 32 BUSY cycles: 33 cycles in total. It is low in DONE, where the instruction advances.
- HI/LO are updated at the clock edge ending DONE.
- mfhi/mflo in the cycle after DONE reads the new values.
- While stalled the input register holds, so the div stays in EX. The FSM must not restart from DONE on that same instruction; DONE always returns to IDLE and the div has advanced.
- Reset mid-division: FSM → IDLE, count → 0, HI/LO → 0, no partial write.
- Reset values: all outputs 0, HI = 0, LO = 0, FSM = IDLE.

## Structure
- `defines.vh` gains:
  - `EX_TO_MEM_WD` = 76, `EX_TO_RF_WD` = 38, `ID_TO_EX_WD` = 159
  - divider state encodings
  - `StallBus`, `Stop`, and `NoStop` are already there.
- One sub-module, `div_iter`: the FSM, counter, and shift registers. It exposes:
  - inputs: start, signed_op, a, b
  - outputs: busy, done, quotient, remainder
- `ex_stage` instantiates `div_iter` and holds the HI/LO registers.

## Test plan
- addu with rs_val = 5, rt_val = 7 → `ex_to_rf_bus` = {1, rd, 32'd12} in the same cycle. lui imm = 16'h1234 → 32'h12340000.
- jal, pc = 32'hBFC00010 → result 32'hBFC00018, rf_waddr = 31.
- sw with base 32'h1000, offset 16'hFFFC, rt_val = 32'hDEADBEEF → en = 1, wen = 4'b1111, addr = 32'h0FFC, wdata = 32'hDEADBEEF.
- divu 100 / 7 → `stallreq_for_ex` high exactly 33 cycles, then LO = 14, HI = 2; a following mflo reads 14.
- div -7 / 2 → LO = 32'hFFFFFFFD, HI = 32'hFFFFFFFF. div 5 / 0 → LO = 32'hFFFFFFFF, HI = 5.
- rst at BUSY count 10 → stallreq drops the next cycle, HI/LO = 0. stall[2]=Stop with stall[3]=NoStop → bubble, rf_we = 0, `data_sram_en` = 0.
